// File: rtl/inst_fetch_if.sv
// Fetch-unit boundary: instruction-memory request/response, redirect input and
// the instruction stream handed to decode.
interface inst_fetch_if;
  // Every valid/ready pair transfers exactly on a cycle where both are high;
  // valid never waits on ready. The response and redirect channels have no
  // ready: they are sampled on every cycle where their valid is high.
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        inst_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_addr, inst_misalign,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_addr, inst_misalign,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// In-order instruction fetch with an address-tagged fetch buffer and redirect
// flush. Define IF_MISALIGN_EXCP_EN to report misaligned redirect targets.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [PW:0] FULL    = PTRW'(DEPTH);

  logic [63:0]      pc;
  logic [63:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW:0]      alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
  logic [PW:0]      used, unfilled, drop_sum, drop_next;
  logic [PW-1:0]    alloc_idx, fill_idx, rd_idx;
  logic [63:0]      target;
  logic             misalign_redir, halted;
  logic             req_valid, req_fire, head_valid, pop;

  assign used      = alloc_ptr - rd_ptr;
  assign unfilled  = alloc_ptr - fill_ptr;
  assign alloc_idx = alloc_ptr[PW-1:0];
  assign fill_idx  = fill_ptr[PW-1:0];
  assign rd_idx    = rd_ptr[PW-1:0];

  assign head_valid = (used != '0) & filled_q[rd_idx];
  assign pop        = head_valid & bus.inst_ready;
  // A pop frees a slot in the same cycle, so a full buffer can still refill.
  assign req_valid  = ~rst & ~bus.redirect_valid & (drop_cnt == '0) & ~halted &
                      ((used != FULL) | pop);
  assign req_fire   = req_valid & bus.imem_req_ready;

  // Old wrong-path responses keep counting; an in-flight response that lands
  // on the redirect cycle is itself one of the responses to throw away.
  assign drop_sum  = drop_cnt + unfilled;
  assign drop_next = drop_sum - ((bus.imem_resp_valid && (drop_sum != '0)) ? PTR_ONE : '0);

`ifdef IF_MISALIGN_EXCP_EN
  assign target         = bus.redirect_pc;
  assign misalign_redir = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted <= misalign_redir;
    end
  end
`else
  assign target         = bus.redirect_pc & ~64'h3;
  assign misalign_redir = 1'b0;
  assign halted         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      filled_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc        <= target;
      rd_ptr    <= '0;
      fill_ptr  <= PTRW'(misalign_redir);
      alloc_ptr <= PTRW'(misalign_redir);
      filled_q  <= DEPTH'(misalign_redir);
      drop_cnt  <= drop_next;
      if (misalign_redir) begin
        addr_q[0] <= target;
        data_q[0] <= 32'h0000_0013;
      end
    end else begin
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_ONE;
        filled_q[rd_idx] <= 1'b0;
      end
      if (req_fire) begin
        addr_q[alloc_idx]   <= pc;
        filled_q[alloc_idx] <= 1'b0;
        alloc_ptr           <= alloc_ptr + PTR_ONE;
        pc                  <= pc + 64'd4;
      end
      // Responses with nothing outstanding are dropped silently.
      if (bus.imem_resp_valid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - PTR_ONE;
        end else if (unfilled != '0) begin
          data_q[fill_idx]   <= bus.imem_resp_data;
          filled_q[fill_idx] <= 1'b1;
          fill_ptr           <= fill_ptr + PTR_ONE;
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = head_valid;
  assign bus.inst           = head_valid ? data_q[rd_idx] : 32'h0;
  assign bus.inst_addr      = head_valid ? addr_q[rd_idx] : 64'h0;
  assign bus.inst_misalign  = head_valid & halted;
endmodule
